chunked_add_sub: RTL and testbench
==================================

# chunked_add_sub

Multi-cycle, parametrised add/subtract unit that evaluates a WIDTH-bit operation through one CHUNK-bit ripple slice per clock, least-significant chunk first. It extends the lab's combinational ripple adders with width and slice parameters, subtraction, signed-overflow detection, an accumulate mode and a start/busy/done handshake. It serves as the arithmetic datapath for the ALU and accumulator labs.

## Interface
- WIDTH, 16, operand and result width; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH.
- clock  in  1  rising-edge clock.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- sub  in  1  0 = add, 1 = subtract.
- acc  in  1  1 = use current sum as operand A; a is ignored.
- ci  in  1  carry in (add) or borrow in (subtract).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when results update.
- sum  out  WIDTH  result, held until the next completion.
- co  out  1  carry out of the MSB; for subtract, 1 = no borrow.
- ovf  out  1  two's-complement overflow.

## Operation
- NCHUNK = WIDTH/CHUNK.
- States:
  - IDLE --start--> RUN.
  - RUN stays NCHUNK cycles, then goes to DONE.
  - DONE lasts one cycle, then returns to IDLE; DONE --start--> RUN directly.
- Operand capture on an accepted start:
  - A = acc ? sum : a.
  - B = sub ? ~b : b.
  - Initial carry = ci ^ sub.
  - Resulting functions: a+b+ci, or a−b−ci when sub = 1.
- Operands and the running carry sit in working registers. Each RUN cycle adds chunk i, i = 0..NCHUNK−1, and stores the slice sum and carry.
- Completion (final RUN edge):
  - sum = assembled result.
  - co = final carry.
  - ovf = carry into the MSB XOR carry out of the MSB.
- sum, co and ovf change only at completion. They are never partially updated.
- start during RUN is ignored and not queued. sub, acc, ci, a and b are don't-care outside the accept cycle.
- CHUNK = WIDTH gives a single RUN cycle.

## Timing
- Reset values: busy = 0, done = 0, sum = 0, co = 0, ovf = 0, state = IDLE, chunk counter = 0.
- Accept at edge k. busy is high from k+1 through k+NCHUNK.
- Results are registered at edge k+NCHUNK. done is high for exactly one cycle after that edge.
- Latency from start to done is NCHUNK+1 edges. Back-to-back throughput is one operation per NCHUNK+1 cycles when start is asserted during done.
- resetn low at any time, including mid-RUN: all outputs and state clear immediately. The aborted operation is lost, and the next start behaves as after power-up.
- Accumulate uses the sum registered before the accept edge, so a chained acc start during done sees the just-completed result.

## Structure
- Shared package/header holds:
  - state encoding constants (IDLE, RUN, DONE);
  - NCHUNK;
  - counter width $clog2(NCHUNK).
- One sub-module, adder_slice #(CHUNK), a purely combinational CHUNK-bit ripple adder.
  - Inputs: a, b, ci.
  - Outputs: s, co, and c_top (carry into its most significant bit, used for ovf).
- Top level contains the FSM, chunk counter, working registers and result registers.

## Test plan
All cases use WIDTH = 16 and CHUNK = 4.
- 0x1234 + 0x0FED, ci = 0, sub = 0 → sum = 0x2221, co = 0, ovf = 0. busy is high for 4 cycles and done pulses on the 5th edge after accept.
- 0xFFFF + 0x0001 → sum = 0x0000, co = 1, ovf = 0. Then 0x7FFF + 0x0001 → sum = 0x8000, co = 0, ovf = 1.
- Subtract 0x0005 − 0x0007, ci = 0 → sum = 0xFFFE, co = 0, ovf = 0. Subtract 0x8000 − 0x0001 → sum = 0x7FFF, co = 1, ovf = 1.
- After reset, acc = 1 with b = 0x0003, issued three times with start asserted during each done → sum = 0x0003, then 0x0006, then 0x0009. A start pulse mid-RUN is ignored: done count stays 3 and sum is unchanged.
- resetn low during the 2nd RUN cycle of 0x1234 + 0x0FED → busy, done, sum, co and ovf read 0 immediately, with no done pulse. A following start of 0x0001 + 0x0001 → sum = 0x0002 after the normal latency.
- CHUNK = 16 instance: 0xABCD + 0x1111 → sum = 0xBCDE with done on the 2nd edge after accept.

Source files
------------

// File: rtl/chunked_add_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : chunked_add_sub_pkg
// Brief    : Shared state encoding and sizing helpers for chunked_add_sub.
// Revision : 1.0  initial release
// ============================================================================
package chunked_add_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    function automatic int nchunk_f(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk configuration still needs a 1-bit counter.
    function automatic int cnt_width_f(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/chunked_add_sub_adder_slice.sv
`default_nettype none
// ============================================================================
// Module   : adder_slice
// Brief    : Combinational CHUNK-bit ripple adder; also exposes the carry into
//            its MSB so the parent can derive signed overflow.
// Revision : 1.0  initial release
// ============================================================================
module adder_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_top
);

    logic [CHUNK:0] carry;

    always_comb begin
        carry    = '0;
        s        = '0;
        carry[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        co    = carry[CHUNK];
        c_top = carry[CHUNK-1];
    end

endmodule
`default_nettype wire

// File: rtl/chunked_add_sub.sv
`default_nettype none
// ============================================================================
// Module   : chunked_add_sub
// Brief    : Multi-cycle add/subtract, one CHUNK-bit slice per clock, LSB first,
//            with accumulate mode and a start/busy/done handshake.
// Revision : 1.0  initial release
// ============================================================================
module chunked_add_sub
    import chunked_add_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic             sub,
    input  logic             acc,
    input  logic             ci,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int               NCHUNK   = nchunk_f(WIDTH, CHUNK);
    localparam int               CNT_W    = cnt_width_f(NCHUNK);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] slice_s;
    logic             slice_co;
    logic             slice_c_top;

    // Operands shift right each cycle so the slice always sees bits [CHUNK-1:0].
    adder_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a     (opa_q[CHUNK-1:0]),
        .b     (opb_q[CHUNK-1:0]),
        .ci    (carry_q),
        .s     (slice_s),
        .co    (slice_co),
        .c_top (slice_c_top)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        part_d  = part_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        co_d    = co_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    opa_d   = acc ? sum_q : a;
                    opb_d   = sub ? ~b : b;
                    carry_d = ci ^ sub;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                opa_d   = opa_q >> CHUNK;
                opb_d   = opb_q >> CHUNK;
                carry_d = slice_co;
                cnt_d   = cnt_q + 1'b1;
                // Slice sums enter at the top; after NCHUNK shifts they are aligned.
                part_d                    = part_q >> CHUNK;
                part_d[WIDTH-1 -: CHUNK]  = slice_s;
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                    sum_d   = part_d;
                    co_d    = slice_co;
                    ovf_d   = slice_co ^ slice_c_top;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            part_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            part_q  <= part_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign co   = co_q;
    assign ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_chunked_add_sub.sv
`default_nettype none
// ============================================================================
// Module   : tb_chunked_add_sub
// Brief    : Directed-vector bench for chunked_add_sub (CHUNK=4 and CHUNK=16).
// Revision : 1.0  initial release
// ============================================================================
module tb_chunked_add_sub;

    logic        clock;
    logic        resetn;
    logic        start, sub, acc, ci;
    logic [15:0] a, b;
    logic        busy, done, co, ovf;
    logic [15:0] sum;

    logic        start2, sub2, acc2, ci2;
    logic [15:0] a2, b2;
    logic        busy2, done2, co2, ovf2;
    logic [15:0] sum2;

    int n_vec;
    int n_err;
    int done_cnt;

    chunked_add_sub #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clock  (clock),
        .resetn (resetn),
        .start  (start),
        .sub    (sub),
        .acc    (acc),
        .ci     (ci),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .co     (co),
        .ovf    (ovf)
    );

    chunked_add_sub #(.WIDTH(16), .CHUNK(16)) u_dut_wide (
        .clock  (clock),
        .resetn (resetn),
        .start  (start2),
        .sub    (sub2),
        .acc    (acc2),
        .ci     (ci2),
        .a      (a2),
        .b      (b2),
        .busy   (busy2),
        .done   (done2),
        .sum    (sum2),
        .co     (co2),
        .ovf    (ovf2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) done_cnt <= 0;
        else if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_res(input string tag, input logic [15:0] es, input logic ec, input logic eo);
        check_val({tag, ".sum"}, {16'h0, sum}, {16'h0, es});
        check_val({tag, ".co"},  {31'h0, co},  {31'h0, ec});
        check_val({tag, ".ovf"}, {31'h0, ovf}, {31'h0, eo});
    endtask

    // Issue one operation on the CHUNK=4 instance; returns just after the done edge.
    task automatic do_op(input string tag, input logic isub, input logic iacc, input logic ici,
                         input logic [15:0] ia, input logic [15:0] ib, input bit pulse_mid);
        int edges;
        int busy_cnt;
        @(negedge clock);
        start = 1'b1; sub = isub; acc = iacc; ci = ici; a = ia; b = ib;
        @(posedge clock); #1;
        start = 1'b0; sub = ~isub; acc = 1'b1; ci = ~ici; a = 16'hDEAD; b = 16'h0100;
        edges    = 1;
        busy_cnt = 0;
        while (!done && edges < 20) begin
            if (busy) busy_cnt++;
            @(posedge clock); #1;
            edges++;
            start = (pulse_mid && edges == 2);
        end
        start = 1'b0;
        check_val({tag, ".latency"}, edges, 5);
        check_val({tag, ".busy_cycles"}, busy_cnt, 4);
    endtask

    initial begin
        int edges;
        n_vec = 0; n_err = 0;
        start = 0; sub = 0; acc = 0; ci = 0; a = '0; b = '0;
        start2 = 0; sub2 = 0; acc2 = 0; ci2 = 0; a2 = '0; b2 = '0;
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_val("reset.busy", {31'h0, busy}, 0);
        check_val("reset.done", {31'h0, done}, 0);
        check_res("reset", 16'h0000, 1'b0, 1'b0);
        check_val("reset.wide_busy", {31'h0, busy2}, 0);
        @(negedge clock);
        resetn = 1'b1;

        do_op("add1", 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0FED, 1'b0);
        check_res("add1", 16'h2221, 1'b0, 1'b0);
        @(posedge clock); #1;
        check_val("add1.done_pulse", {31'h0, done}, 0);
        check_res("add1.hold", 16'h2221, 1'b0, 1'b0);

        do_op("wrap", 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 1'b0);
        check_res("wrap", 16'h0000, 1'b1, 1'b0);
        do_op("povf", 1'b0, 1'b0, 1'b0, 16'h7FFF, 16'h0001, 1'b0);
        check_res("povf", 16'h8000, 1'b0, 1'b1);
        do_op("addci", 1'b0, 1'b0, 1'b1, 16'h00FF, 16'h0000, 1'b0);
        check_res("addci", 16'h0100, 1'b0, 1'b0);
        do_op("sub1", 1'b1, 1'b0, 1'b0, 16'h0005, 16'h0007, 1'b0);
        check_res("sub1", 16'hFFFE, 1'b0, 1'b0);
        do_op("subovf", 1'b1, 1'b0, 1'b0, 16'h8000, 16'h0001, 1'b0);
        check_res("subovf", 16'h7FFF, 1'b1, 1'b1);
        do_op("subbi", 1'b1, 1'b0, 1'b1, 16'h0010, 16'h0001, 1'b0);
        check_res("subbi", 16'h000E, 1'b1, 1'b0);

        // Accumulate chain from a clean reset, each start issued during done.
        @(negedge clock); resetn = 1'b0;
        @(negedge clock); resetn = 1'b1;
        do_op("acc1", 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0003, 1'b0);
        check_val("acc1.sum", {16'h0, sum}, 32'h0003);
        do_op("acc2", 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0003, 1'b0);
        check_val("acc2.sum", {16'h0, sum}, 32'h0006);
        do_op("acc3", 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0003, 1'b1);
        check_val("acc3.sum", {16'h0, sum}, 32'h0009);
        repeat (10) @(posedge clock);
        #1;
        check_val("acc.done_count", done_cnt, 3);
        check_val("acc.sum_hold", {16'h0, sum}, 32'h0009);
        check_val("acc.idle_busy", {31'h0, busy}, 0);

        // Abort in the second RUN cycle.
        @(negedge clock);
        start = 1'b1; sub = 1'b0; acc = 1'b0; ci = 1'b0; a = 16'h1234; b = 16'h0FED;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        resetn = 1'b0;
        #1;
        check_val("abort.busy", {31'h0, busy}, 0);
        check_val("abort.done", {31'h0, done}, 0);
        check_res("abort", 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            check_val("abort.no_done", {31'h0, done}, 0);
        end
        @(negedge clock); resetn = 1'b1;
        do_op("post_abort", 1'b0, 1'b0, 1'b0, 16'h0001, 16'h0001, 1'b0);
        check_res("post_abort", 16'h0002, 1'b0, 1'b0);

        // Single-slice instance.
        @(negedge clock);
        start2 = 1'b1; a2 = 16'hABCD; b2 = 16'h1111;
        @(posedge clock); #1;
        start2 = 1'b0; a2 = 16'h5555; b2 = 16'h5555;
        edges = 1;
        while (!done2 && edges < 20) begin
            @(posedge clock); #1;
            edges++;
        end
        check_val("wide.latency", edges, 2);
        check_val("wide.sum", {16'h0, sum2}, 32'hBCDE);
        check_val("wide.co", {31'h0, co2}, 0);
        check_val("wide.ovf", {31'h0, ovf2}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
